// File: rtl/led_cycle_ctrl.sv
// RGB colour-wheel sequencer: a six-phase hue cycle driven by a ms tick
// prescaler, controlled by a small command FSM (IDLE / RUN / PAUSE).
//
// Command handshake: a command transfers on any rising clk edge where
// cmd_valid && cmd_ready are both high. cmd_ready is high in every state
// once reset has been released. An accepted command that is illegal in the
// current state leaves the state alone and raises cmd_err for one cycle.
module led_cycle_ctrl #(
    parameter int TICK_DIV    = 12000,
    parameter int DWELL_STEPS = 167,
    localparam int DW = $clog2(DWELL_STEPS),
    localparam int TW = $clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    input  logic [2:0]    cmd_op,
    output logic          cmd_ready,
    output logic          cmd_err,
    output logic [DW-1:0] r_duty,
    output logic [DW-1:0] g_duty,
    output logic [DW-1:0] b_duty,
    output logic [2:0]    phase,
    output logic          running,
    output logic          ms_tick,
    output logic          cycle_done,
    output logic [1:0]    dbg_state
);

    localparam logic [DW-1:0] DUTY_MAX  = DW'(DWELL_STEPS - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_START  = 3'd1;
    localparam logic [2:0] OP_PAUSE  = 3'd2;
    localparam logic [2:0] OP_RESUME = 3'd3;
    localparam logic [2:0] OP_STOP   = 3'd4;
    localparam logic [2:0] OP_STEP   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tick_cnt, tick_nxt;
    logic [DW-1:0] step_cnt, step_nxt;
    logic [2:0]    phase_nxt;
    logic          err_nxt, done_nxt;
    logic          accepted, do_step;

    assign accepted  = cmd_valid && cmd_ready;
    assign ms_tick   = (state == S_RUN) && (tick_cnt == TICK_LAST);
    assign running   = (state == S_RUN);
    assign dbg_state = state;

    // State and counter registers; cmd_ready rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            tick_cnt   <= '0;
            step_cnt   <= '0;
            phase      <= '0;
            cmd_ready  <= 1'b0;
            cmd_err    <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_nxt;
            step_cnt   <= step_nxt;
            phase      <= phase_nxt;
            cmd_ready  <= 1'b1;
            cmd_err    <= err_nxt;
            cycle_done <= done_nxt;
        end
    end

    // Next-state: prescaler runs in RUN, steps come from ms ticks or STEP,
    // and STOP overrides everything else on the same edge.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        step_nxt  = step_cnt;
        phase_nxt = phase;
        err_nxt   = 1'b0;
        done_nxt  = 1'b0;
        do_step   = ms_tick;

        if (state == S_RUN) begin
            tick_nxt = ms_tick ? '0 : tick_cnt + 1'b1;
        end

        if (accepted) begin
            case (cmd_op)
                OP_NOP: ;
                OP_START: begin
                    if (state == S_IDLE) begin
                        state_nxt = S_RUN;
                        tick_nxt  = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                OP_PAUSE: begin
                    if (state == S_RUN) state_nxt = S_PAUSE;
                    else                err_nxt   = 1'b1;
                end
                OP_RESUME: begin
                    if (state == S_PAUSE) state_nxt = S_RUN;
                    else                  err_nxt   = 1'b1;
                end
                OP_STOP: ;
                OP_STEP: begin
                    if (state == S_PAUSE) do_step = 1'b1;
                    else                  err_nxt = 1'b1;
                end
                default: err_nxt = 1'b1;
            endcase
        end

        if (do_step) begin
            if (step_cnt == DUTY_MAX) begin
                step_nxt  = '0;
                phase_nxt = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
                done_nxt  = (phase == 3'd5);
            end else begin
                step_nxt = step_cnt + 1'b1;
            end
        end

        if (accepted && (cmd_op == OP_STOP)) begin
            state_nxt = S_IDLE;
            tick_nxt  = '0;
            step_nxt  = '0;
            phase_nxt = '0;
            done_nxt  = 1'b0;
        end
    end

    // Colour wheel: each phase ramps exactly one channel up or down.
    always_comb begin
        r_duty = '0;
        g_duty = '0;
        b_duty = '0;
        if (state != S_IDLE) begin
            case (phase)
                3'd0: begin r_duty = DUTY_MAX;            g_duty = step_cnt;            b_duty = '0;                  end
                3'd1: begin r_duty = DUTY_MAX - step_cnt; g_duty = DUTY_MAX;            b_duty = '0;                  end
                3'd2: begin r_duty = '0;                  g_duty = DUTY_MAX;            b_duty = step_cnt;            end
                3'd3: begin r_duty = '0;                  g_duty = DUTY_MAX - step_cnt; b_duty = DUTY_MAX;            end
                3'd4: begin r_duty = step_cnt;            g_duty = '0;                  b_duty = DUTY_MAX;            end
                3'd5: begin r_duty = DUTY_MAX;            g_duty = '0;                  b_duty = DUTY_MAX - step_cnt; end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_cycle_ctrl.sv
// Bench for led_cycle_ctrl with TICK_DIV=4, DWELL_STEPS=3: command table,
// directed multi-cycle sequences, then random commands against a model
// that tracks position along the colour wheel as a single ms count.
module tb_led_cycle_ctrl;

    localparam int TDIV = 4;
    localparam int DWELL = 3;
    localparam int MAXD = DWELL - 1;
    localparam int WHEEL = 6 * DWELL;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic       cmd_ready, cmd_err, running, ms_tick, cycle_done;
    logic [1:0] r_duty, g_duty, b_duty;
    logic [2:0] phase;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int m_state = M_IDLE;
    int m_tick = 0;
    int m_pos = 0;
    int m_err = 0;
    int m_done = 0;
    int m_ready = 0;

    // per channel behaviour in each phase: 0 off, 1 full, 2 ramp up, 3 ramp down
    int mode_tbl [3][6] = '{'{1, 3, 0, 0, 2, 1}, '{2, 1, 1, 3, 0, 0}, '{0, 0, 2, 1, 1, 3}};

    typedef struct {
        logic [2:0] op;
        int         exp_err;
        int         exp_run;
    } vec_t;
    vec_t vecs[13];

    led_cycle_ctrl #(.TICK_DIV(TDIV), .DWELL_STEPS(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .cmd_err(cmd_err), .r_duty(r_duty), .g_duty(g_duty),
        .b_duty(b_duty), .phase(phase), .running(running), .ms_tick(ms_tick),
        .cycle_done(cycle_done), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int mdl_duty(input int ch);
        int s, mode;
        if (m_state == M_IDLE) return 0;
        s = m_pos % DWELL;
        mode = mode_tbl[ch][m_pos / DWELL];
        case (mode)
            1: return MAXD;
            2: return s;
            3: return MAXD - s;
            default: return 0;
        endcase
    endfunction

    function automatic int is_illegal(input int op, input int st);
        case (op)
            0, 4: return 0;
            1: return int'(st != M_IDLE);
            2: return int'(st != M_RUN);
            3, 5: return int'(st != M_PAUSE);
            default: return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_tick = 0; m_pos = 0; m_err = 0; m_done = 0; m_ready = 0;
    endtask

    // one clock edge of the reference model
    task automatic model_step(input logic v, input logic [2:0] op_l);
        int op, acc, tick_now, adv, nstate;
        op = int'(op_l);
        acc = int'(v) & m_ready;
        tick_now = int'(m_state == M_RUN && m_tick == TDIV - 1);
        adv = tick_now | int'(acc == 1 && op == 5 && m_state == M_PAUSE);
        m_err = (acc == 1) ? is_illegal(op, m_state) : 0;
        m_ready = 1;
        nstate = m_state;
        if (acc == 1 && m_err == 0) begin
            if (op == 1) nstate = M_RUN;
            if (op == 2) nstate = M_PAUSE;
            if (op == 3) nstate = M_RUN;
        end
        if (m_state == M_RUN) m_tick = (m_tick + 1) % TDIV;
        m_done = 0;
        if (adv == 1) begin
            m_done = int'(m_pos == WHEEL - 1);
            m_pos = (m_pos + 1) % WHEEL;
        end
        m_state = nstate;
        if (acc == 1 && op == 4) begin
            m_state = M_IDLE; m_tick = 0; m_pos = 0; m_done = 0;
        end
    endtask

    task automatic compare_all();
        check("cmd_ready", int'(cmd_ready), m_ready);
        check("cmd_err", int'(cmd_err), m_err);
        check("running", int'(running), int'(m_state == M_RUN));
        check("ms_tick", int'(ms_tick), int'(m_state == M_RUN && m_tick == TDIV - 1));
        check("cycle_done", int'(cycle_done), m_done);
        check("phase", int'(phase), m_pos / DWELL);
        check("r_duty", int'(r_duty), mdl_duty(0));
        check("g_duty", int'(g_duty), mdl_duty(1));
        check("b_duty", int'(b_duty), mdl_duty(2));
    endtask

    // driver: offer (v, op) for one edge, then compare after the edge
    task automatic cycle(input logic v, input logic [2:0] op);
        cmd_valid = v;
        cmd_op = op;
        @(posedge clk);
        model_step(v, op);
        #1;
        compare_all();
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 3'd0);
    endtask

    initial begin
        int cnt, ok;
        logic [2:0] rop;
        logic rv;

        vecs[0]  = '{3'd3, 1, 0};  // RESUME in IDLE
        vecs[1]  = '{3'd0, 0, 0};  // NOP
        vecs[2]  = '{3'd7, 1, 0};  // illegal opcode
        vecs[3]  = '{3'd1, 0, 1};  // START
        vecs[4]  = '{3'd1, 1, 1};  // START in RUN
        vecs[5]  = '{3'd2, 0, 0};  // PAUSE
        vecs[6]  = '{3'd2, 1, 0};  // PAUSE in PAUSE
        vecs[7]  = '{3'd5, 0, 0};  // STEP
        vecs[8]  = '{3'd3, 0, 1};  // RESUME
        vecs[9]  = '{3'd5, 1, 1};  // STEP in RUN
        vecs[10] = '{3'd6, 1, 1};  // illegal opcode
        vecs[11] = '{3'd4, 0, 0};  // STOP
        vecs[12] = '{3'd4, 0, 0};  // STOP in IDLE

        // reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 3'd0);
        check("ready_after_reset", int'(cmd_ready), 1);

        // command legality table
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, vecs[i].op);
            check($sformatf("vec%0d_err", i), int'(cmd_err), vecs[i].exp_err);
            check($sformatf("vec%0d_run", i), int'(running), vecs[i].exp_run);
            cycle(1'b0, 3'd0);
            check($sformatf("vec%0d_err_pulse", i), int'(cmd_err), 0);
        end

        // START then three ticks -> phase 1, R=G=MAX
        cycle(1'b1, 3'd1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 3'd0);
            if (ms_tick) cnt++;
        end
        check("ticks_in_12", cnt, 3);
        check("p1_phase", int'(phase), 1);
        check("p1_r", int'(r_duty), 2);
        check("p1_g", int'(g_duty), 2);

        // 15 more ticks complete the wheel
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 3'd0);
            if (cycle_done) cnt++;
        end
        check("wheel_cycle_done", cnt, 1);
        check("wheel_phase", int'(phase), 0);
        check("wheel_r", int'(r_duty), 2);
        check("wheel_g", int'(g_duty), 0);
        check("wheel_b", int'(b_duty), 0);

        // pause at step 1, freeze, step twice, resume
        cycle(1'b1, 3'd4);
        cycle(1'b1, 3'd1);
        idle(4);
        cycle(1'b1, 3'd2);
        cnt = 0; ok = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 3'd0);
            if (ms_tick) cnt++;
            if (r_duty != 2'd2 || g_duty != 2'd1 || b_duty != 2'd0) ok = 0;
        end
        check("pause_ticks", cnt, 0);
        check("pause_frozen", ok, 1);
        cycle(1'b1, 3'd5);
        cycle(1'b1, 3'd5);
        check("step_phase", int'(phase), 1);
        check("step_r", int'(r_duty), 2);
        check("step_g", int'(g_duty), 2);
        cycle(1'b1, 3'd3);
        cnt = 0;
        while (!ms_tick && cnt < 10) begin
            cycle(1'b0, 3'd0);
            cnt++;
        end
        check("resume_tick_delay", cnt, 2);

        // STOP on the tick that would wrap phase 5 -> 0
        cycle(1'b1, 3'd4);
        cycle(1'b1, 3'd1);
        cnt = 0;
        while (!(m_pos == WHEEL - 1 && m_tick == TDIV - 1) && cnt < 200) begin
            cycle(1'b0, 3'd0);
            cnt++;
        end
        check("reach_p5s2", int'(cnt < 200), 1);
        check("p5s2_tick", int'(ms_tick), 1);
        cycle(1'b1, 3'd4);
        check("stop_run", int'(running), 0);
        check("stop_done", int'(cycle_done), 0);
        check("stop_duty", int'({r_duty, g_duty, b_duty}), 0);

        // asynchronous reset mid-RUN in phase 3
        cycle(1'b1, 3'd1);
        cnt = 0;
        while (m_pos / DWELL != 3 && cnt < 200) begin
            cycle(1'b0, 3'd0);
            cnt++;
        end
        check("reach_p3", int'(phase), 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_ready", int'(cmd_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 3'd0);
        check("rel_ready", int'(cmd_ready), 1);
        check("rel_run", int'(running), 0);

        // random commands against the model
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            rop = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(0, 7));
            cycle(rv, rop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
